chunk_writer: RTL and testbench

- Write-side master for the chunk memory. The display path reads this memory, turns each chunk into pixels and drives VGA.
- Accepts rectangle-fill commands in chunk coordinates from game logic. Clamps each rectangle to the grid.
- Issues one chunk write per clock in row-major order: data_in, write_x_chunk, write_y_chunk, plus a write strobe.
- Reports busy, done and error so the game FSM can sequence screen updates.

---
 rtl/chunk_pkg.sv | 32 +++
 rtl/chunk_writer_if.sv | 42 ++++
 rtl/rect_scanner.sv | 72 +++++++
 rtl/chunk_writer.sv | 137 +++++++++++++
 tb/tb_chunk_writer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/chunk_pkg.sv
// Shared constants, coordinate/tile types and writer FSM states for the chunk memory write path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package chunk_pkg;

    // Pixel edge of one chunk. Kept for reference by the display path; no writer logic uses it.
    localparam int CHUNK_SIZE = 16;
    localparam int GRID_W     = 40;   // chunk columns (640 / CHUNK_SIZE)
    localparam int GRID_H     = 30;   // chunk rows    (480 / CHUNK_SIZE)
    localparam int DATA_W     = 2;    // bits per tile code

    typedef logic [5:0]        chunk_x_t;
    typedef logic [4:0]        chunk_y_t;
    typedef logic [DATA_W-1:0] tile_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } wr_state_t;

    // Saturate an inclusive right/bottom edge to the last valid column/row.
    function automatic chunk_x_t clamp_x(input chunk_x_t x);
        return (x > chunk_x_t'(GRID_W - 1)) ? chunk_x_t'(GRID_W - 1) : x;
    endfunction

    function automatic chunk_y_t clamp_y(input chunk_y_t y);
        return (y > chunk_y_t'(GRID_H - 1)) ? chunk_y_t'(GRID_H - 1) : y;
    endfunction

endpackage

// File: rtl/chunk_writer_if.sv
// Command channel (game logic -> writer) and write channel (writer -> chunk memory).
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready on the command channel; the write channel is a plain strobe with no stall.

// Command side: master is the command source, slave is the writer.
interface chunk_cmd_if;
    import chunk_pkg::*;

    logic     cmd_valid;
    logic     cmd_ready;
    chunk_x_t cmd_x0;
    chunk_y_t cmd_y0;
    chunk_x_t cmd_x1;
    chunk_y_t cmd_y1;
    tile_t    cmd_data;
    logic     busy;
    logic     done;
    logic     err;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_data,
        input  cmd_ready, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_data,
        output cmd_ready, busy, done, err
    );
endinterface

// Memory side: master is the writer, slave is the chunk memory.
interface chunk_wr_if;
    import chunk_pkg::*;

    logic     wr_en;
    chunk_x_t write_x_chunk;
    chunk_y_t write_y_chunk;
    tile_t    data_in;

    modport master (output wr_en, write_x_chunk, write_y_chunk, data_in);
    modport slave  (input  wr_en, write_x_chunk, write_y_chunk, data_in);
endinterface

// File: rtl/rect_scanner.sv
// Row-major x/y cursor over an inclusive rectangle, with a combinational last-position flag.
// Latency: load or step takes effect on the next clk edge; last reflects the current cursor.
// Backpressure: none; the cursor only moves when step is asserted.
//
// Ports: clk, reset (sync, active-high); load + x0/y0/x1/y1 start a scan at (x0,y0);
// step advances one position; cx/cy are the registered cursor, last is high at (x1,y1).
module rect_scanner
    import chunk_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load,
    input  logic     step,
    input  chunk_x_t x0,
    input  chunk_y_t y0,
    input  chunk_x_t x1,
    input  chunk_y_t y1,
    output chunk_x_t cx,
    output chunk_y_t cy,
    output logic     last
);

    chunk_x_t cx_q, cx_d;
    chunk_y_t cy_q, cy_d;
    chunk_x_t x0_q, x0_d;
    chunk_x_t x1_q, x1_d;
    chunk_y_t y1_q, y1_d;

    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        x0_d = x0_q;
        x1_d = x1_q;
        y1_d = y1_q;
        if (load) begin
            cx_d = x0;
            cy_d = y0;
            x0_d = x0;
            x1_d = x1;
            y1_d = y1;
        end else if (step) begin
            // The owner never steps past (x1,y1), so cy cannot run off the grid.
            if (cx_q == x1_q) begin
                cx_d = x0_q;
                cy_d = chunk_y_t'(cy_q + 1'b1);
            end else begin
                cx_d = chunk_x_t'(cx_q + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
            x0_q <= x0_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
        end
    end

    assign cx   = cx_q;
    assign cy   = cy_q;
    assign last = (cx_q == x1_q) && (cy_q == y1_q);

endmodule

// File: rtl/chunk_writer.sv
// Rectangle-fill write master for the chunk memory: clamps the command to the grid and writes one chunk per clock, row-major.
// Latency: handshake at edge N -> CHECK cycle, first wr_en one edge later, done pulse the cycle after the last write.
// Backpressure: cmd_ready only in IDLE; no command queueing, the source holds cmd_valid until accepted.
//
// Ports: clk, reset (sync, active-high); cmd (chunk_cmd_if.slave): cmd_valid/cmd_ready handshake,
// cmd_x0/y0/x1/y1/data, status busy/done/err; wr (chunk_wr_if.master): wr_en, write_x_chunk,
// write_y_chunk, data_in. Write channel and status outputs are all registered.
module chunk_writer
    import chunk_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    chunk_cmd_if.slave  cmd,
    chunk_wr_if.master  wr
);

    wr_state_t state_q, state_d;

    chunk_x_t x0_q, x0_d;
    chunk_y_t y0_q, y0_d;
    chunk_x_t x1_q, x1_d;
    chunk_y_t y1_q, y1_d;
    tile_t    data_q, data_d;

    logic wr_en_q, wr_en_d;
    logic busy_q,  busy_d;
    logic done_q,  done_d;
    logic err_q,   err_d;

    logic     accept;
    logic     reject;
    chunk_x_t x1_clamp;
    chunk_y_t y1_clamp;
    logic     scan_load;
    logic     scan_step;
    logic     scan_last;
    chunk_x_t scan_x;
    chunk_y_t scan_y;

    assign accept = (state_q == ST_IDLE) && cmd.cmd_valid;

    // Only the far edge is clamped; an out-of-grid near edge cannot be repaired and is rejected.
    assign x1_clamp = clamp_x(x1_q);
    assign y1_clamp = clamp_y(y1_q);
    assign reject   = (x0_q >= chunk_x_t'(GRID_W)) ||
                      (y0_q >= chunk_y_t'(GRID_H)) ||
                      (x0_q > x1_clamp) ||
                      (y0_q > y1_clamp);

    assign scan_load = (state_q == ST_CHECK) && !reject;
    assign scan_step = (state_q == ST_WRITE) && !scan_last;

    rect_scanner u_scan (
        .clk   (clk),
        .reset (reset),
        .load  (scan_load),
        .step  (scan_step),
        .x0    (x0_q),
        .y0    (y0_q),
        .x1    (x1_clamp),
        .y1    (y1_clamp),
        .cx    (scan_x),
        .cy    (scan_y),
        .last  (scan_last)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_CHECK;
            ST_CHECK:  state_d = reject ? ST_IDLE : ST_WRITE;
            ST_WRITE:  if (scan_last) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and command-latch logic; status flags follow the state being entered so they register cleanly.
    always_comb begin
        x0_d   = x0_q;
        y0_d   = y0_q;
        x1_d   = x1_q;
        y1_d   = y1_q;
        data_d = data_q;
        if (accept) begin
            x0_d   = cmd.cmd_x0;
            y0_d   = cmd.cmd_y0;
            x1_d   = cmd.cmd_x1;
            y1_d   = cmd.cmd_y1;
            data_d = cmd.cmd_data;
        end
        wr_en_d = (state_d == ST_WRITE);
        busy_d  = (state_d == ST_CHECK) || (state_d == ST_WRITE);
        done_d  = (state_d == ST_FINISH);
        err_d   = (state_q == ST_CHECK) && reject;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Held low while reset is asserted so nothing is offered during the reset cycle.
    assign cmd.cmd_ready = (state_q == ST_IDLE) && !reset;
    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;
    assign cmd.err       = err_q;

    // The scanner cursor is registered and only moves while writing, so it doubles as the write address.
    assign wr.wr_en         = wr_en_q;
    assign wr.write_x_chunk = scan_x;
    assign wr.write_y_chunk = scan_y;
    assign wr.data_in       = data_q;

endmodule

// File: tb/tb_chunk_writer.sv
module tb_chunk_writer;
    import chunk_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    chunk_cmd_if cmd_if ();
    chunk_wr_if  wr_if ();

    chunk_writer dut (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_if),
        .wr    (wr_if)
    );

    // cyc = number of rising edges so far; everything is sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
        int d;
        int cyc;
    } wr_exp_t;

    typedef struct {
        int kind;   // 0 = done, 1 = err
        int cyc;
    } evt_exp_t;

    wr_exp_t  exp_wr[$];
    evt_exp_t exp_evt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write, done or err.
    always @(negedge clk) begin : mon
        wr_exp_t  e;
        evt_exp_t v;
        logic     in_grid;
        if (wr_if.wr_en === 1'b1) begin
            in_grid = (wr_if.write_x_chunk < 6'd40) && (wr_if.write_y_chunk < 5'd30);
            chk("wr_in_grid", 32'(in_grid), 32'd1);
            chk("wr_busy", 32'(cmd_if.busy), 32'd1);
            if (exp_wr.size() == 0) begin
                fail("wr_unexpected");
            end else begin
                e = exp_wr.pop_front();
                chk("wr_x",     32'(wr_if.write_x_chunk), e.x);
                chk("wr_y",     32'(wr_if.write_y_chunk), e.y);
                chk("wr_data",  32'(wr_if.data_in),       e.d);
                chk("wr_cycle", cyc,                      e.cyc);
            end
        end
        if (cmd_if.done === 1'b1) begin
            chk("done_busy_low", 32'(cmd_if.busy), 32'd0);
            chk("done_writes_left", exp_wr.size(), 32'd0);
            if (exp_evt.size() == 0) begin
                fail("done_unexpected");
            end else begin
                v = exp_evt.pop_front();
                chk("done_kind",  32'd0, v.kind);
                chk("done_cycle", cyc,   v.cyc);
            end
        end
        if (cmd_if.err === 1'b1) begin
            chk("err_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
            if (exp_evt.size() == 0) begin
                fail("err_unexpected");
            end else begin
                v = exp_evt.pop_front();
                chk("err_kind",  32'd1, v.kind);
                chk("err_cycle", cyc,   v.cyc);
            end
        end
    end

    // Drive a command and hold it until accepted; hs is the index of the handshake edge.
    task automatic send(input int x0, input int y0, input int x1, input int y1, input int d,
                        output int hs);
        int n;
        @(negedge clk);
        cmd_if.cmd_x0    = 6'(x0);
        cmd_if.cmd_y0    = 5'(y0);
        cmd_if.cmd_x1    = 6'(x1);
        cmd_if.cmd_y1    = 5'(y1);
        cmd_if.cmd_data  = 2'(d);
        cmd_if.cmd_valid = 1'b1;
        for (n = 0; n < 5000 && cmd_if.cmd_ready !== 1'b1; n++) @(negedge clk);
        if (cmd_if.cmd_ready !== 1'b1) begin
            fail("send_timeout");
            hs = -1000;
        end else begin
            hs = cyc + 1;
        end
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    // Expected writes for an already-clamped rectangle; done only if the scan is not cut short.
    task automatic expect_rect(input int hs, input int x0, input int y0, input int x1, input int y1,
                               input int d, input int max_n, output int count);
        wr_exp_t  e;
        evt_exp_t v;
        int k = 0;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (k < max_n) begin
                    e.x = x; e.y = y; e.d = d; e.cyc = hs + 1 + k;
                    exp_wr.push_back(e);
                end
                k++;
            end
        end
        count = k;
        if (k <= max_n) begin
            v.kind = 0; v.cyc = hs + 1 + k;
            exp_evt.push_back(v);
        end
    endtask

    task automatic expect_err(input int hs);
        evt_exp_t v;
        v.kind = 1; v.cyc = hs + 1;
        exp_evt.push_back(v);
    endtask

    initial begin
        int hs, hs_full, n_full, n, hs2;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_x0    = '0;
        cmd_if.cmd_y0    = '0;
        cmd_if.cmd_x1    = '0;
        cmd_if.cmd_y1    = '0;
        cmd_if.cmd_data  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_if.cmd_ready),     32'd0);
        chk("rst_wr_en", 32'(wr_if.wr_en),          32'd0);
        chk("rst_busy",  32'(cmd_if.busy),          32'd0);
        chk("rst_done",  32'(cmd_if.done),          32'd0);
        chk("rst_err",   32'(cmd_if.err),           32'd0);
        chk("rst_x",     32'(wr_if.write_x_chunk),  32'd0);
        chk("rst_y",     32'(wr_if.write_y_chunk),  32'd0);
        chk("rst_data",  32'(wr_if.data_in),        32'd0);
        reset = 1'b0;
        #1 chk("post_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);

        // Single chunk.
        send(5, 3, 5, 3, 2, hs);
        expect_rect(hs, 5, 3, 5, 3, 2, 100000, n);

        // 3x2 rectangle.
        send(0, 0, 2, 1, 1, hs);
        expect_rect(hs, 0, 0, 2, 1, 1, 100000, n);

        // Clamped at the bottom-right corner.
        send(38, 28, 63, 31, 3, hs);
        expect_rect(hs, 38, 28, 39, 29, 3, 100000, n);

        // Rejects: inverted x, then x0 off the grid.
        send(10, 0, 4, 0, 1, hs);
        expect_err(hs);
        send(45, 2, 50, 3, 1, hs);
        expect_err(hs);

        // Full clear, with the next command offered while busy.
        send(0, 0, 39, 29, 0, hs_full);
        expect_rect(hs_full, 0, 0, 39, 29, 0, 100000, n_full);
        send(1, 1, 1, 1, 2, hs2);
        chk("held_cmd_accept_edge", hs2, hs_full + 1200 + 3);
        expect_rect(hs2, 1, 1, 1, 1, 2, 100000, n);

        // Reset during the 4th write of a 3x2 rectangle.
        send(0, 0, 2, 1, 3, hs);
        expect_rect(hs, 0, 0, 2, 1, 3, 4, n);
        for (int i = 0; i < 20 && cyc != hs + 4; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_wr_en", 32'(wr_if.wr_en),     32'd0);
        chk("abort_busy",  32'(cmd_if.busy),     32'd0);
        chk("abort_done",  32'(cmd_if.done),     32'd0);
        chk("abort_ready", 32'(cmd_if.cmd_ready), 32'd0);
        reset = 1'b0;
        #1 chk("abort_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
        send(7, 7, 7, 7, 1, hs);
        expect_rect(hs, 7, 7, 7, 7, 1, 100000, n);

        // Drain the scoreboard.
        for (int i = 0; i < 3000 && (exp_wr.size() != 0 || exp_evt.size() != 0); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        chk("writes_left", exp_wr.size(),  32'd0);
        chk("events_left", exp_evt.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        fail("global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
